multicycle_controller: RTL



---
 rtl/multicycle_controller_pkg.sv | 52 +++++
 rtl/mc_output_decoder.sv | 54 +++++
 rtl/multicycle_controller.sv | 82 ++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: state encoding, opcodes, select encodings and control word
package multicycle_controller_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_SHIFT = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       branch;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;
endpackage

// File: rtl/mc_output_decoder.sv
// mc_output_decoder: Moore decode of the registered state into the control word
//   state_i  current FSM state
//   ctrl_o   control word; all zero for illegal state codes
module mc_output_decoder
    import multicycle_controller_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = ALUB_FOUR;
            end
            S_DECODE: ctrl_o.alu_src_b = ALUB_SHIFT;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = PC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src   = PC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS-style control FSM
//   clk, rst           clock and synchronous active-high reset
//   opcode, zero       instruction opcode (sampled in DECODE/MEMADR) and ALU zero flag
//   write enables      pc_write, ir_write, mem_write, reg_write
//   selects            iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src
//   pc_en, state       PC load enable and debug state
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [3:0] state
);
    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_out;

    always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_output_decoder u_dec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // During reset every enable is killed and the selects park at their FETCH values.
    always_comb begin
        ctrl_out = ctrl;
        if (rst) begin
            ctrl_out = '0;
            ctrl_out.alu_src_b = ALUB_FOUR;
        end
    end

    assign pc_write   = ctrl_out.pc_write;
    assign ir_write   = ctrl_out.ir_write;
    assign mem_write  = ctrl_out.mem_write;
    assign reg_write  = ctrl_out.reg_write;
    assign iord       = ctrl_out.iord;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign alu_op     = ctrl_out.alu_op;
    assign pc_src     = ctrl_out.pc_src;
    assign pc_en      = ctrl_out.pc_write | (ctrl_out.branch & zero);
    assign state      = state_q;
endmodule
